// File: rtl/wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
//   Shared definitions for the writeback port arbiter.
//   - Default widths and requester count.
//   - wb_req_t: one writeback request (destination index + data) at default widths.
// Optional feature macro used by the top: WB_ARB_BYPASS_EN.
// -----------------------------------------------------------------------------
package wb_arb_pkg;

    localparam int XLEN_D = 32;
    localparam int AW_D   = 5;
    localparam int NREQ_D = 3;

    typedef struct packed {
        logic [AW_D-1:0]   rd;
        logic [XLEN_D-1:0] wd;
    } wb_req_t;

endpackage : wb_arb_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin search. Starting at ptr and wrapping explicitly at
//   N-1 -> 0, the first asserted req bit wins. Nothing wins while en is low.
// Ports
//   req     in   N    request vector
//   ptr     in   PW   index with highest priority this cycle
//   en      in   1    search enable
//   grant   out  N    one-hot grant (all zero when no winner)
//   winner  out  PW   index of the granted requester (0 when none)
// -----------------------------------------------------------------------------
module rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int N  = NREQ_D,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] winner
);

    logic          w_found;
    logic [PW-1:0] w_idx;
    int            w_sum;

    always_comb begin
        grant   = '0;
        winner  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        w_sum   = 0;
        if (en) begin
            for (int i = 0; i < N; i++) begin
                // Explicit wrap so non-power-of-two N never visits an unused index.
                w_sum = int'(ptr) + i;
                if (w_sum >= N) begin
                    w_sum = w_sum - N;
                end
                w_idx = PW'(w_sum);
                if (!w_found && req[w_idx]) begin
                    w_found       = 1'b1;
                    grant[w_idx]  = 1'b1;
                    winner        = w_idx;
                end
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//   Shares the register file's single write port between NREQ writeback
//   requesters. Round-robin, one grant per cycle, valid/ready handshake; the
//   winning write is registered and drives the register file one cycle later.
//   Optional macro WB_ARB_BYPASS_EN enables combinational forwarding of the
//   in-flight write to the two read indices; otherwise fwd_* are tied to 0.
// Ports
//   clk_i, reset_i         clock (rising edge), synchronous active-high reset
//   hold_i                 stall: no grants while high
//   req_valid_i [NREQ]     write pending per requester
//   req_rd_i [NREQ*AW]     destination index, requester n at [n*AW +: AW]
//   req_wd_i [NREQ*XLEN]   write data, requester n at [n*XLEN +: XLEN]
//   req_ready_o [NREQ]     one-hot grant
//   regwrite_o/rd_o/wd_o   register file write port
//   rs1_i, rs2_i           register file read indices
//   fwd_a_valid_o/fwd_a_o  forward for rs1
//   fwd_b_valid_o/fwd_b_o  forward for rs2
// -----------------------------------------------------------------------------
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NREQ = NREQ_D,
    parameter int XLEN = XLEN_D,
    parameter int AW   = AW_D
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 hold_i,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [NREQ*AW-1:0]   req_rd_i,
    input  logic [NREQ*XLEN-1:0] req_wd_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic                 regwrite_o,
    output logic [AW-1:0]        rd_o,
    output logic [XLEN-1:0]      wd_o,
    input  logic [AW-1:0]        rs1_i,
    input  logic [AW-1:0]        rs2_i,
    output logic                 fwd_a_valid_o,
    output logic [XLEN-1:0]      fwd_a_o,
    output logic                 fwd_b_valid_o,
    output logic [XLEN-1:0]      fwd_b_o
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]   r_ptr;
    logic            r_regwrite;
    logic [AW-1:0]   r_rd;
    logic [XLEN-1:0] r_wd;

    logic [NREQ-1:0] w_grant;
    logic [PW-1:0]   w_winner;
    logic            w_en;
    logic            w_fire;
    logic [AW-1:0]   w_sel_rd;
    logic [XLEN-1:0] w_sel_wd;
    logic [PW-1:0]   w_ptr_nxt;

    // Reset also blocks grants so no requester believes it was accepted.
    assign w_en = !hold_i && !reset_i;

    rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (
        .req    (req_valid_i),
        .ptr    (r_ptr),
        .en     (w_en),
        .grant  (w_grant),
        .winner (w_winner)
    );

    assign req_ready_o = w_grant;
    assign w_fire      = |w_grant;
    assign w_sel_rd    = req_rd_i[int'(w_winner)*AW +: AW];
    assign w_sel_wd    = req_wd_i[int'(w_winner)*XLEN +: XLEN];
    assign w_ptr_nxt   = (w_winner == PW'(NREQ-1)) ? '0 : w_winner + PW'(1);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_ptr      <= '0;
            r_regwrite <= 1'b0;
            r_rd       <= '0;
            r_wd       <= '0;
        end else if (w_fire) begin
            r_ptr      <= w_ptr_nxt;
            r_rd       <= w_sel_rd;
            r_wd       <= w_sel_wd;
            // x0 writes are consumed but never reach the register file.
            r_regwrite <= (w_sel_rd != '0);
        end else begin
            r_regwrite <= 1'b0;
        end
    end

    assign regwrite_o = r_regwrite;
    assign rd_o       = r_rd;
    assign wd_o       = r_wd;

`ifdef WB_ARB_BYPASS_EN
    // Covers the cycle before the register file has committed the write.
    assign fwd_a_valid_o = r_regwrite && (r_rd == rs1_i) && (rs1_i != '0);
    assign fwd_a_o       = r_wd;
    assign fwd_b_valid_o = r_regwrite && (r_rd == rs2_i) && (rs2_i != '0);
    assign fwd_b_o       = r_wd;
`else
    assign fwd_a_valid_o = 1'b0;
    assign fwd_a_o       = '0;
    assign fwd_b_valid_o = 1'b0;
    assign fwd_b_o       = '0;
`endif

endmodule : wb_port_arbiter
